// File: rtl/seq_alu_if.sv
// Request/response bundle between decode, seq_alu and write-back.
// Master drives the request; slave returns result and flags.
interface seq_alu_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [4:0]   OpCode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] alu_out;
  logic [N-1:0] alu_out_hi;
  logic         V;
  logic         C;
  logic         N_;
  logic         Z_;
  logic         dz;
  logic         illegal;

  modport master (
    output start, OpCode, a, b, cin,
    input  busy, done, alu_out, alu_out_hi, V, C, N_, Z_, dz, illegal
  );

  modport slave (
    input  start, OpCode, a, b, cin,
    output busy, done, alu_out, alu_out_hi, V, C, N_, Z_, dz, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide behind a start/done handshake.
module seq_alu #(
  parameter int unsigned N = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int unsigned LW  = $clog2(N);
  localparam int unsigned CW  = LW + 1;
  localparam int unsigned NP1 = N + 1;

  localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_MUL  = 5'h02, OP_DIV  = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04, OP_OR   = 5'h05, OP_XOR  = 5'h06, OP_NOR  = 5'h07;
  localparam logic [4:0] OP_NAND = 5'h08, OP_XNOR = 5'h09;
  localparam logic [4:0] OP_EQ   = 5'h0A, OP_NEQ  = 5'h0B, OP_LT   = 5'h0C, OP_LTE  = 5'h0D;
  localparam logic [4:0] OP_GT   = 5'h0E, OP_GTE  = 5'h0F;
  localparam logic [4:0] OP_SHL  = 5'h10, OP_SHR  = 5'h11, OP_ROL  = 5'h12, OP_ROR  = 5'h13;

  typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [N-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic           v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d;
  logic           dz_q, dz_d, ill_q, ill_d;
  logic [2*N-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;

  logic [N-1:0]   r_lo;
  logic           r_v, r_c, r_n, r_z, r_ill;
  logic [N:0]     sum, diff;
  logic [LW-1:0]  amt;
  logic [2*N-1:0] acc_step;
  logic [N:0]     shifted;
  logic           q_bit;
  logic [N-1:0]   rem_next;

  // Single-cycle result and flags straight from the request operands.
  always_comb begin
    amt   = bus.b[LW-1:0];
    sum   = {1'b0, bus.a} + {1'b0, bus.b} + NP1'(bus.cin);
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    r_lo  = '0;
    r_v   = 1'b0;
    r_c   = 1'b0;
    r_n   = 1'b0;
    r_z   = 1'b0;
    r_ill = 1'b0;
    case (bus.OpCode)
      OP_ADD: begin
        r_lo = sum[N-1:0];
        r_c  = sum[N];
        r_v  = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
        r_n  = sum[N-1];
        r_z  = (sum[N-1:0] == '0);
      end
      OP_SUB: begin
        r_lo = diff[N-1:0];
        r_c  = ~diff[N];
        r_v  = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
        r_n  = diff[N-1];
        r_z  = (diff[N-1:0] == '0);
      end
      OP_MUL, OP_DIV: r_lo = '0;
      OP_AND:  r_lo = bus.a & bus.b;
      OP_OR:   r_lo = bus.a | bus.b;
      OP_XOR:  r_lo = bus.a ^ bus.b;
      OP_NOR:  r_lo = ~(bus.a | bus.b);
      OP_NAND: r_lo = ~(bus.a & bus.b);
      OP_XNOR: r_lo = ~(bus.a ^ bus.b);
      OP_EQ:   r_lo = N'(bus.a == bus.b);
      OP_NEQ:  r_lo = N'(bus.a != bus.b);
      OP_LT:   r_lo = N'(bus.a <  bus.b);
      OP_LTE:  r_lo = N'(bus.a <= bus.b);
      OP_GT:   r_lo = N'(bus.a >  bus.b);
      OP_GTE:  r_lo = N'(bus.a >= bus.b);
      OP_SHL:  r_lo = bus.a << amt;
      OP_SHR:  r_lo = bus.a >> amt;
      // A shift by the full width yields 0, so amount 0 passes a through.
      OP_ROL:  r_lo = (bus.a << amt) | (bus.a >> (CW'(N) - CW'(amt)));
      OP_ROR:  r_lo = (bus.a >> amt) | (bus.a << (CW'(N) - CW'(amt)));
      default: r_ill = 1'b1;
    endcase
  end

  // One multiplier bit and one restoring-divide quotient bit per step.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    shifted  = {rem_q, quot_q[N-1]};
    q_bit    = (shifted >= {1'b0, dvsr_q});
    rem_next = q_bit ? (shifted[N-1:0] - dvsr_q) : shifted[N-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lo_d     = lo_q;
    hi_d     = hi_q;
    v_d      = v_q;
    c_d      = c_q;
    n_d      = n_q;
    z_d      = z_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.OpCode == OP_MUL) begin
            mcand_d  = {{N{1'b0}}, bus.a};
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = CW'(N);
            busy_d   = 1'b1;
            state_d  = MUL_IT;
          end else if (bus.OpCode == OP_DIV) begin
            quot_d  = bus.a;
            dvsr_d  = bus.b;
            rem_d   = '0;
            cnt_d   = CW'(N);
            busy_d  = 1'b1;
            state_d = DIV_IT;
          end else begin
            lo_d   = r_lo;
            hi_d   = '0;
            v_d    = r_v;
            c_d    = r_c;
            n_d    = r_n;
            z_d    = r_z;
            dz_d   = 1'b0;
            ill_d  = r_ill;
            done_d = 1'b1;
          end
        end
      end
      MUL_IT: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          lo_d    = acc_step[N-1:0];
          hi_d    = acc_step[2*N-1:N];
          {v_d, c_d, n_d, z_d, dz_d, ill_d} = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DIV_IT: begin
        rem_d  = rem_next;
        quot_d = {quot_q[N-2:0], q_bit};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          lo_d    = {quot_q[N-2:0], q_bit};
          hi_d    = rem_next;
          {v_d, c_d, n_d, z_d, ill_d} = '0;
          dz_d    = (dvsr_q == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      v_q      <= v_d;
      c_q      <= c_d;
      n_q      <= n_d;
      z_q      <= z_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.alu_out    = lo_q;
  assign bus.alu_out_hi = hi_q;
  assign bus.V          = v_q;
  assign bus.C          = c_q;
  assign bus.N_         = n_q;
  assign bus.Z_         = z_q;
  assign bus.dz         = dz_q;
  assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at N=8 and N=16: directed requests push
// hand-computed results; per-instance monitors pop and compare on done.
module tb_seq_alu;
  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_MUL = 5'h02, OP_DIV = 5'h03;
  localparam logic [4:0] OP_XOR = 5'h06, OP_NAND = 5'h08, OP_LT = 5'h0C, OP_GTE = 5'h0F;
  localparam logic [4:0] OP_SHL = 5'h10, OP_SHR = 5'h11, OP_ROL = 5'h12, OP_ROR = 5'h13;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [5:0]  fl;   // {V, C, N_, Z_, dz, illegal}
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.N(8))  if8 ();
  seq_alu_if #(.N(16)) if16 ();

  seq_alu #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  seq_alu #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  exp_t  q8[$];
  exp_t  q16[$];
  string n8[$];
  string n16[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] lo, input logic [15:0] hi, input logic [5:0] fl);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    e.fl = fl;
    return e;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 16) ? if16.done : if8.done;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 16) ? if16.busy : if8.busy;
  endfunction

  function automatic logic [15:0] get_lo(input int w);
    return (w == 16) ? if16.alu_out : 16'(if8.alu_out);
  endfunction

  function automatic logic [15:0] get_hi(input int w);
    return (w == 16) ? if16.alu_out_hi : 16'(if8.alu_out_hi);
  endfunction

  function automatic logic [5:0] get_fl(input int w);
    if (w == 16) return {if16.V, if16.C, if16.N_, if16.Z_, if16.dz, if16.illegal};
    return {if8.V, if8.C, if8.N_, if8.Z_, if8.dz, if8.illegal};
  endfunction

  function automatic logic [39:0] get_all(input int w);
    return {get_lo(w), get_hi(w), get_fl(w), get_busy(w), get_done(w)};
  endfunction

  task automatic drive(input int w, input logic st, input logic [4:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic cin);
    if (w == 16) begin
      if16.start = st; if16.OpCode = op; if16.a = a; if16.b = b; if16.cin = cin;
    end else begin
      if8.start = st; if8.OpCode = op; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin;
    end
  endtask

  task automatic monitor(input int w);
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (get_done(w)) begin
        if ((w == 16) ? (q16.size() == 0) : (q8.size() == 0)) begin
          chk($sformatf("spurious done w%0d", w), 64'(get_done(w)), 64'd0);
        end else begin
          if (w == 16) begin e = q16.pop_front(); nm = n16.pop_front(); end
          else         begin e = q8.pop_front();  nm = n8.pop_front();  end
          chk({nm, " lo"},    64'(get_lo(w)), 64'(e.lo));
          chk({nm, " hi"},    64'(get_hi(w)), 64'(e.hi));
          chk({nm, " flags"}, 64'(get_fl(w)), 64'(e.fl));
        end
      end
    end
  endtask

  // Issue one request, then wait (bounded) for done and check timing.
  task automatic issue(input int w, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input string nm,
                       input exp_t e, input bit pulse);
    int lat, busyc, explat, expbusy;
    bit got;
    if (w == 16) begin q16.push_back(e); n16.push_back(nm); end
    else         begin q8.push_back(e);  n8.push_back(nm);  end
    @(negedge clk);
    drive(w, 1'b1, op, a, b, cin);
    lat = 0; busyc = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (get_done(w)) got = 1'b1;
      else if (get_busy(w)) busyc++;
      if (pulse && lat == 3) drive(w, 1'b1, OP_ADD, 16'h0001, 16'h0002, 1'b0);
      else drive(w, 1'b0, op, a, b, cin);
    end
    explat  = (op == OP_MUL || op == OP_DIV) ? w + 1 : 1;
    expbusy = (op == OP_MUL || op == OP_DIV) ? w : 0;
    chk({nm, " latency"}, 64'(lat), 64'(explat));
    chk({nm, " busy cycles"}, 64'(busyc), 64'(expbusy));
    chk({nm, " busy at done"}, 64'(get_busy(w)), 64'd0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1;
    drive(8, 1'b0, 5'h00, 16'h0, 16'h0, 1'b0);
    drive(16, 1'b0, 5'h00, 16'h0, 16'h0, 1'b0);
    fork
      monitor(8);
      monitor(16);
    join_none
    repeat (3) @(negedge clk);
    chk("reset outputs w8", get_all(8), 40'd0);
    chk("reset outputs w16", get_all(16), 40'd0);
    rst = 1'b0;

    issue(8, OP_ADD,  16'h7F, 16'h01, 1'b0, "add 7f+01",    mk(16'h80, 0, 6'b101000), 0);
    issue(8, OP_SUB,  16'h05, 16'h05, 1'b0, "sub 05-05",    mk(16'h00, 0, 6'b010100), 0);
    issue(8, OP_MUL,  16'hFF, 16'hFF, 1'b0, "mul ff*ff",    mk(16'h01, 16'hFE, 6'b0), 1);
    issue(8, OP_DIV,  16'd200, 16'd7, 1'b0, "div 200/7",    mk(16'h1C, 16'h04, 6'b0), 0);
    issue(8, OP_DIV,  16'h55, 16'h00, 1'b0, "div 55/0",     mk(16'hFF, 16'h55, 6'b000010), 0);
    issue(8, OP_ROL,  16'h81, 16'h03, 1'b0, "rol 81,3",     mk(16'h0C, 0, 6'b0), 0);
    issue(8, OP_SHR,  16'h80, 16'h09, 1'b0, "shr 80,9",     mk(16'h40, 0, 6'b0), 0);
    issue(8, OP_LT,   16'h03, 16'h05, 1'b0, "lt 3,5",       mk(16'h01, 0, 6'b0), 0);
    issue(8, OP_GTE,  16'h03, 16'h05, 1'b0, "gte 3,5",      mk(16'h00, 0, 6'b0), 0);
    issue(8, 5'h1F,   16'hAA, 16'h55, 1'b0, "illegal 1f",   mk(16'h00, 0, 6'b000001), 0);
    issue(8, OP_ADD,  16'hFF, 16'h00, 1'b1, "add ff+0+1",   mk(16'h00, 0, 6'b010100), 0);
    issue(8, OP_SUB,  16'h03, 16'h05, 1'b0, "sub 03-05",    mk(16'hFE, 0, 6'b001000), 0);
    issue(8, OP_SUB,  16'h80, 16'h01, 1'b0, "sub 80-01",    mk(16'h7F, 0, 6'b110000), 0);
    issue(8, OP_XOR,  16'hF0, 16'h3C, 1'b0, "xor f0,3c",    mk(16'hCC, 0, 6'b0), 0);
    issue(8, OP_NAND, 16'hF0, 16'h3C, 1'b0, "nand f0,3c",   mk(16'hCF, 0, 6'b0), 0);
    issue(8, OP_SHL,  16'h01, 16'h00, 1'b0, "shl 01,0",     mk(16'h01, 0, 6'b0), 0);
    issue(8, OP_ROR,  16'h01, 16'h01, 1'b0, "ror 01,1",     mk(16'h80, 0, 6'b0), 0);

    // Abort a multiply with reset in its fourth busy cycle.
    @(negedge clk);
    drive(8, 1'b1, OP_MUL, 16'hFF, 16'hFF, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, OP_MUL, 16'hFF, 16'hFF, 1'b0);
    chk("mul busy before abort", 64'(get_busy(8)), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort outputs w8", get_all(8), 40'd0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (get_done(8)) done_seen++;
    end
    chk("done after abort", 64'(done_seen), 64'd0);
    issue(8, OP_ADD, 16'h01, 16'h02, 1'b0, "add after abort", mk(16'h03, 0, 6'b0), 0);

    issue(16, OP_ADD, 16'h7FFF, 16'h0001, 1'b0, "w16 add 7fff+1", mk(16'h8000, 0, 6'b101000), 0);
    issue(16, OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, "w16 mul",        mk(16'h0001, 16'hFFFE, 6'b0), 0);
    issue(16, OP_DIV, 16'd50000, 16'd7,  1'b0, "w16 div",         mk(16'd7142, 16'd6, 6'b0), 0);

    repeat (2) @(negedge clk);
    chk("scoreboard drained w8", 64'(q8.size()), 64'd0);
    chk("scoreboard drained w16", 64'(q16.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, sequential successor to the combinational 8-bit datapath ALU. It adds a registered start/done handshake, a real multi-cycle unsigned multiply and divide (previously stubbed to zero), and variable shift/rotate amounts. It produces a double-width result port and sticky-until-next-op flags. It sits between the decode stage and the register-file write-back; decode holds operands stable only for the `start` cycle.

## Interface
Parameters:
- `N`, default 8: operand/result width; must be ≥ 4 and a power of two.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `OpCode`  in  5  operation select (map below).
- `a`, `b`  in  N  operands; captured on the accepted `start` edge.
- `cin`  in  1  carry-in, ADD only.
- `busy`  out  1  high while a MUL/DIV is iterating.
- `done`  out  1  one-cycle pulse when `alu_out`/flags are valid for the accepted op.
- `alu_out`  out  N  low result: sum/diff/logic/compare/shift, MUL low half, DIV quotient.
- `alu_out_hi`  out  N  MUL high half, DIV remainder; 0 for all other ops.
- `V`, `C`, `N_`, `Z_`  out  1 each  overflow, carry, negative, zero flags.
- `dz`  out  1  divide-by-zero indication for the last op.
- `illegal`  out  1  last accepted OpCode was unmapped.

## Operation
Opcode map (hex):
- 00 ADD: a+b+cin.
- 01 SUB: a−b.
- 02 MUL: unsigned, 2N-bit product.
- 03 DIV: unsigned quotient/remainder.
- 04 AND, 05 OR, 06 XOR, 07 NOR, 08 NAND, 09 XNOR.
- 0A–0F compare, unsigned, in the order EQ, NEQ, LT, LTE, GT, GTE. Result is zero-extended: 1 if true, else 0.
- 10 SHL, 11 SHR (logical), 12 ROL, 13 ROR. Amount is b[$clog2(N)-1:0] (b mod N); amount 0 returns a.
- 14–1F: illegal. alu_out=0, alu_out_hi=0, flags 0, `illegal`=1.

Flags:
- ADD: C = carry out of bit N−1; V = signed overflow; N_ = result[N−1]; Z_ = (result==0).
- SUB: C = 1 when a ≥ b unsigned (no borrow); V, N_, Z_ as for ADD.
- All other ops clear V, C, N_, Z_. `dz` and `illegal` are 0 except as stated.

FSM (IDLE, MUL_IT, DIV_IT):
- IDLE + `start` + single-cycle op: result and flags registered on the same edge; `done`=1 in the following cycle; stays IDLE.
- IDLE + `start` + MUL: load multiplicand, multiplier, and a 2N-bit accumulator cleared to 0; counter=N; go to MUL_IT. Shift-add, one multiplier bit per cycle.
- IDLE + `start` + DIV: restoring division, one quotient bit per cycle; go to DIV_IT. If b==0, still iterate N cycles; final quotient = all ones, remainder = a, `dz`=1.
- MUL_IT/DIV_IT: decrement counter each cycle. At counter==1, write alu_out/alu_out_hi, return to IDLE, assert `done` the next cycle.
- `start` while `busy`=1 is ignored: no queuing, no effect on the running op.
- Outputs hold their last values between ops; they change only on the cycle `done` rises, or on reset.
- Illegal opcodes complete as single-cycle ops.

## Timing
- Reset: every output is 0 (busy, done, alu_out, alu_out_hi, V, C, N_, Z_, dz, illegal). The FSM is in IDLE and the counter is 0.
- Reset mid-MUL/DIV: abort; the next cycle shows busy=0 and all outputs 0, with no `done` pulse. `start` is accepted in the cycle after `rst` deasserts.
- Single-cycle op latency: start at edge k, `done` high for cycle k+1 only.
- MUL/DIV: start at edge k; `busy`=1 for cycles k+1 … k+N; `done`=1 at cycle k+N+1 with `busy`=0. Back-to-back `start` is accepted in the `done` cycle.
- `done` never stays high for two consecutive cycles unless two single-cycle ops are issued on consecutive edges.
- Operands/OpCode are don't-care except on the accepting edge.

## Test plan
- N=8, ADD a=0x7F b=0x01 cin=0 → cycle+1: done=1, alu_out=0x80, V=1, C=0, N_=1, Z_=0. Then SUB a=0x05 b=0x05 → 0x00, Z_=1, C=1, V=0.
- MUL a=0xFF b=0xFF → busy 8 cycles; done at cycle 9 with alu_out_hi=0xFE, alu_out=0x01, flags 0. A `start` with ADD pulsed at cycle 3 → ignored, result unchanged.
- DIV a=200 b=7 → done after 8 busy cycles with alu_out=28 (0x1C), alu_out_hi=4, dz=0. Then DIV a=0x55 b=0x00 → alu_out=0xFF, alu_out_hi=0x55, dz=1.
- ROL a=0x81 b=3 → 0x0C. SHR a=0x80 b=9 → 0x40 (amount mod 8 = 1). LT a=3 b=5 → 0x01. GTE a=3 b=5 → 0x00. OpCode 0x1F → alu_out=0, illegal=1.
- Assert rst during MUL_IT cycle 4 → next cycle busy=0, all outputs 0, no done. Then ADD 0x01+0x02 → 0x03 with done one cycle later.
- Re-run ADD/MUL/DIV with N=16: MUL 0xFFFF×0xFFFF → hi 0xFFFE, lo 0x0001, busy 16 cycles.
